// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller:
// defaults, FSM encoding and stage indices for a vector stall bus.
package pipe_ctrl_pkg;

  localparam int REGADDR_W_DEF  = 5;
  localparam int MULDIV_LAT_DEF = 4;
  localparam int PERF_W_DEF     = 32;

  typedef enum logic {
    RUN    = 1'b0,
    FROZEN = 1'b1
  } ctrl_state_e;

  // Bit positions of the stall bus, PC first.
  localparam int STG_PC    = 0;
  localparam int STG_IFID  = 1;
  localparam int STG_IDEX  = 2;
  localparam int STG_EXMEM = 3;
  localparam int STG_MEMWB = 4;
  localparam int NUM_STG   = 5;

  // Source-operand match against a producing destination register.
  function automatic logic src_hit(input logic use_src,
                                   input logic [31:0] src,
                                   input logic [31:0] dst);
    return use_src && (src == dst);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_muldiv.sv
// Mult/div occupancy tracker: loads on a start, counts down every cycle
// regardless of pipeline stalls.
module muldiv_busy_tracker
  import pipe_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT = MULDIV_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic freeze_i,
  output logic busy_o
);

  localparam int CNT_W = $clog2(MULDIV_LAT + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MULDIV_LAT - 1);

  logic [CNT_W-1:0] busy_cnt_q;
  logic [CNT_W-1:0] busy_cnt_d;

  // Next count: a start that is not frozen reloads, even if already busy.
  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (start_i && !freeze_i) begin
      busy_cnt_d = LOAD_VAL;
    end else if (busy_cnt_q != {CNT_W{1'b0}}) begin
      busy_cnt_d = busy_cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      busy_cnt_d = busy_cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt_q <= {CNT_W{1'b0}};
    end else begin
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_o = (busy_cnt_q != {CNT_W{1'b0}});

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush generator for the 5-stage pipeline: hazard detection,
// priority mux, freeze FSM and stall-cycle performance counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT = MULDIV_LAT_DEF,
  parameter int REGADDR_W  = REGADDR_W_DEF,
  parameter int PERF_W     = PERF_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REGADDR_W-1:0] id_rs_i,
  input  logic [REGADDR_W-1:0] id_rt_i,
  input  logic                 id_use_rs_i,
  input  logic                 id_use_rt_i,
  input  logic                 id_hilo_use_i,
  input  logic [REGADDR_W-1:0] ex_rd_i,
  input  logic                 ex_memread_i,
  input  logic                 ex_muldiv_start_i,
  input  logic                 branch_taken_i,
  input  logic                 mem_wait_i,
  output logic                 stall_pc_o,
  output logic                 stall_ifid_o,
  output logic                 stall_idex_o,
  output logic                 stall_exmem_o,
  output logic                 stall_memwb_o,
  output logic                 flush_ifid_o,
  output logic                 bubble_idex_o,
  output logic                 muldiv_busy_o,
  output logic [PERF_W-1:0]    stall_cycles_o
);

  ctrl_state_e        state_q, state_d;
  logic [PERF_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [NUM_STG-1:0] stall_vec_s;
  logic               flush_s, bubble_s;
  logic               busy_s, load_use_s, hilo_s;

  muldiv_busy_tracker #(.MULDIV_LAT(MULDIV_LAT)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (ex_muldiv_start_i),
    .freeze_i (mem_wait_i),
    .busy_o   (busy_s)
  );

  assign load_use_s = ex_memread_i && (ex_rd_i != {REGADDR_W{1'b0}}) &&
                      (src_hit(id_use_rs_i, 32'(id_rs_i), 32'(ex_rd_i)) ||
                       src_hit(id_use_rt_i, 32'(id_rt_i), 32'(ex_rd_i)));
  assign hilo_s     = id_hilo_use_i && (busy_s || ex_muldiv_start_i);

  // Priority mux; a taken branch under a hazard is dropped since it is re-resolved after the stall.
  always_comb begin
    stall_vec_s = {NUM_STG{1'b0}};
    flush_s     = 1'b0;
    bubble_s    = 1'b0;
    if (!rst_n) begin
      stall_vec_s = {NUM_STG{1'b0}};
    end else if (mem_wait_i) begin
      stall_vec_s = {NUM_STG{1'b1}};
    end else if (load_use_s || hilo_s) begin
      stall_vec_s[STG_PC]   = 1'b1;
      stall_vec_s[STG_IFID] = 1'b1;
      bubble_s              = 1'b1;
    end else if (branch_taken_i) begin
      flush_s = 1'b1;
    end else begin
      flush_s = 1'b0;
    end
  end

  // Freeze tracking FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (mem_wait_i) state_d = FROZEN;
        else            state_d = RUN;
      end
      FROZEN: begin
        if (!mem_wait_i) state_d = RUN;
        else             state_d = FROZEN;
      end
      default: state_d = RUN;
    endcase
  end

  // Stall-cycle counter, wraps naturally.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_vec_s[STG_PC]) begin
      stall_cycles_d = stall_cycles_q + {{(PERF_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      stall_cycles_q <= {PERF_W{1'b0}};
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_pc_o     = stall_vec_s[STG_PC];
  assign stall_ifid_o   = stall_vec_s[STG_IFID];
  assign stall_idex_o   = stall_vec_s[STG_IDEX];
  assign stall_exmem_o  = stall_vec_s[STG_EXMEM];
  assign stall_memwb_o  = stall_vec_s[STG_MEMWB];
  assign flush_ifid_o   = flush_s;
  assign bubble_idex_o  = bubble_s;
  assign muldiv_busy_o  = busy_s;
  assign stall_cycles_o = stall_cycles_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush generator for the 5-stage MIPS32 pipeline.
- It is the driving end of the stall/clear interface that every pipeline register consumes.
- It detects load-use hazards, multi-cycle mult/div occupancy, data-memory wait and taken branches, then drives per-register stall and bubble (synchronous-clear) controls.
- One instance per core; it sits between the ID/EX/MEM control decode and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- MULDIV_LAT, 4, cycles the mult/div unit is busy after a start (≥2).
- REGADDR_W, 5, register-address width.
- PERF_W, 32, width of the stall-cycle performance counter.

Ports:
- Clk  in  1  core clock.
- Reset  in  1  asynchronous, active-low reset.
- id_rs  in  REGADDR_W  source register rs of the instruction in ID.
- id_rt  in  REGADDR_W  source register rt of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_hilo_use  in  1  ID instruction is mfhi/mflo/mult/div.
- ex_rd  in  REGADDR_W  destination register of the instruction in EX.
- ex_memread  in  1  EX instruction is a load.
- ex_muldiv_start  in  1  EX instruction starts mult/div this cycle.
- branch_taken  in  1  branch/jump resolved taken in ID.
- mem_wait  in  1  data memory not ready; MEM stage must hold.
- stall_pc  out  1  hold PC.
- stall_ifid  out  1  hold IF/ID.
- stall_idex  out  1  hold ID/EX.
- stall_exmem  out  1  hold EX/MEM.
- stall_memwb  out  1  hold MEM/WB.
- flush_ifid  out  1  clear IF/ID to a NOP next edge.
- bubble_idex  out  1  clear ID/EX to a NOP next edge.
- muldiv_busy  out  1  mult/div unit occupied.
- stall_cycles  out  PERF_W  count of cycles with stall_pc=1.

Behaviour:
- Stall/flush outputs are combinational from the current inputs and registered state. Pipeline registers sample them at the same Clk edge (zero latency).
- Load-use hazard: ex_memread && ex_rd!=0 && ((id_use_rs && id_rs==ex_rd) || (id_use_rt && id_rt==ex_rd)).
- HI/LO hazard: id_hilo_use && (muldiv_busy || ex_muldiv_start).
- Priority, highest first:
  - Freeze (mem_wait=1): all five stall outputs =1; flush_ifid=0; bubble_idex=0. Nothing else is acted on.
  - Load-use or HI/LO hazard: stall_pc=stall_ifid=1; bubble_idex=1; stall_idex/exmem/memwb=0; flush_ifid=0. A branch_taken in the same cycle is ignored, because the branch sits in ID and is re-evaluated after the stall.
  - branch_taken: flush_ifid=1; all stalls 0.
  - Otherwise all outputs 0.
- Mult/div counter, busy_cnt of ceil(log2(MULDIV_LAT+1)) bits:
  - ex_muldiv_start with no freeze loads MULDIV_LAT-1.
  - Otherwise it decrements when nonzero, every cycle, freeze included; the unit runs independently of pipeline stalls.
  - muldiv_busy = (busy_cnt != 0).
  - A start while busy is impossible by construction (blocked by the HI/LO hazard). If it occurs anyway, the counter reloads.
- FSM, registered state {RUN, FROZEN}:
  - RUN→FROZEN when mem_wait=1.
  - FROZEN→RUN when mem_wait=0. On that first RUN cycle the hazard logic re-evaluates normally, with no extra recovery cycle.
  - State feeds only the performance counter and debug; outputs do not depend on it beyond mem_wait.
- stall_cycles increments by 1 each cycle stall_pc=1, including the freeze and hazard cases. It wraps modulo 2^PERF_W.
- Reset (Reset=0, asynchronous):
  - state=RUN, busy_cnt=0, stall_cycles=0.
  - All stall, flush and bubble outputs forced to 0 while Reset=0, independent of inputs.
  - Assertion mid-mult/div discards the pending busy count.
- Register $zero (ex_rd==0) never creates a load-use hazard.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - REGADDR_W default.
  - FSM state encoding RUN/FROZEN.
  - Stage-index constants PC/IFID/IDEX/EXMEM/MEMWB, for any vector form of the stall bus.
- Natural sub-module: muldiv_busy_tracker, holding busy_cnt load/decrement and muldiv_busy.
- The top level holds the hazard compare, the priority mux, the FSM and stall_cycles.

Test Plan:
- Load-use: lw $t0 in EX (ex_memread=1, ex_rd=8), ID add with id_rs=8, id_use_rs=1 → exactly one cycle of stall_pc=stall_ifid=bubble_idex=1; stall_cycles 0→1. With ex_rd=0, nothing is asserted.
- Mult/div: ex_muldiv_start=1 with MULDIV_LAT=4, then mflo in ID next cycle → muldiv_busy high for 3 cycles after the start edge, stall_pc/bubble_idex high for those 3 cycles, released the cycle busy_cnt reaches 0.
- Memory wait: mem_wait=1 for 3 cycles during a pending load-use → all five stalls =1 and no bubble for 3 cycles. Then one load-use bubble cycle follows, and stall_cycles advances by 4.
- Branch vs. hazard: branch_taken=1 with a simultaneous load-use → bubble only, flush_ifid=0. Next cycle branch_taken=1 with no hazard → flush_ifid=1 for one cycle.
- Reset mid-operation: assert Reset=0 asynchronously between edges with busy_cnt=2 and mem_wait=1 → all outputs 0 immediately, and stall_cycles=0. After release, muldiv_busy=0 and the FSM is in RUN.
